// File: rtl/multicycle_pkg.sv
// Shared constants and state encoding for the multicycle MIPS control unit.
package multicycle_pkg;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRtypeEx = 4'd6,
        StRtypeWb = 4'd7,
        StBeqEx   = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJumpEx  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic       SRCA_PC    = 1'b0;
    localparam logic       SRCA_REGA  = 1'b1;
    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // StFetch doubles as the "undecodable opcode" result.
    function automatic state_t decode_next(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW: return StMemAdr;
            OP_RTYPE:     return StRtypeEx;
            OP_BEQ:       return StBeqEx;
            OP_ADDI:      return StAddiEx;
            OP_J:         return StJumpEx;
            default:      return StFetch;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// R-type funct field to ALU operation select, with a validity flag.
module alu_decoder
    import multicycle_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl,
    output logic       funct_valid
);

    always_comb begin
        alu_ctrl    = ALU_ADD;
        funct_valid = 1'b1;
        case (funct)
            FN_ADD:  alu_ctrl = ALU_ADD;
            FN_SUB:  alu_ctrl = ALU_SUB;
            FN_AND:  alu_ctrl = ALU_AND;
            FN_OR:   alu_ctrl = ALU_OR;
            FN_SLT:  alu_ctrl = ALU_SLT;
            default: funct_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: fetch, decode, execute,
// memory and writeback sequencing with a memory-ready handshake.
module multicycle_control
    import multicycle_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] ALUcontrol,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    state_t     state;
    logic [3:0] rtype_alu;
    logic       funct_valid;

    alu_decoder u_alu_decoder (
        .funct       (funct),
        .alu_ctrl    (rtype_alu),
        .funct_valid (funct_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= StFetch;
        end else begin
            case (state)
                StFetch:   if (mem_ready) state <= StDecode;
                StDecode:  state <= decode_next(opcode);
                StMemAdr:  state <= (opcode == OP_SW) ? StMemWr : StMemRd;
                StMemRd:   if (mem_ready) state <= StMemWb;
                StMemWb:   state <= StFetch;
                StMemWr:   if (mem_ready) state <= StFetch;
                StRtypeEx: state <= funct_valid ? StRtypeWb : StFetch;
                StRtypeWb: state <= StFetch;
                StBeqEx:   state <= StFetch;
                StAddiEx:  state <= StAddiWb;
                StAddiWb:  state <= StFetch;
                StJumpEx:  state <= StFetch;
                default:   state <= StFetch;
            endcase
        end
    end

    assign state_o = state;

    always_comb begin
        ALUcontrol = ALU_ADD;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_REGB;
        pc_src     = PCSRC_ALU;
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal_op = 1'b0;

        case (state)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            StDecode: begin
                alu_src_b  = SRCB_IMMSH;
                illegal_op = (decode_next(opcode) == StFetch);
            end
            StMemAdr: begin
                alu_src_a = SRCA_REGA;
                alu_src_b = SRCB_IMM;
            end
            StMemRd: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            StMemWr: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            StRtypeEx: begin
                alu_src_a  = SRCA_REGA;
                ALUcontrol = rtype_alu;
                illegal_op = ~funct_valid;
            end
            StRtypeWb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            StBeqEx: begin
                alu_src_a  = SRCA_REGA;
                ALUcontrol = ALU_SUB;
                pc_src     = PCSRC_ALUOUT;
                pc_en      = zero;
            end
            StAddiEx: begin
                alu_src_a = SRCA_REGA;
                alu_src_b = SRCB_IMM;
            end
            StAddiWb: begin
                reg_write = 1'b1;
            end
            StJumpEx: begin
                pc_src = PCSRC_JUMP;
                pc_en  = 1'b1;
            end
            default: ;
        endcase

        // State is already FETCH during reset; suppress its read and any writes.
        if (reset) begin
            pc_en      = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: one full output vector checked per cycle.
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic [3:0] ALUcontrol;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_en, iord, mem_read, mem_write, ir_write;
    logic       reg_write, reg_dst, mem_to_reg, illegal_op;
    logic [3:0] state_o;

    int checks = 0;
    int errors = 0;

    multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .ALUcontrol (ALUcontrol),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .pc_en      (pc_en),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .illegal_op (illegal_op),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [21:0] obs;
    assign obs = {state_o, ALUcontrol, alu_src_a, alu_src_b, pc_src, pc_en, iord,
                  mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, illegal_op};

    logic [9:0] rst_obs;
    assign rst_obs = {state_o, pc_en, ir_write, reg_write, mem_read, mem_write, illegal_op};

    function automatic logic [21:0] v(input logic [3:0] st, input logic [3:0] alu,
                                      input logic a, input logic [1:0] b,
                                      input logic [1:0] pcs, input logic pce,
                                      input logic io, input logic mr, input logic mw,
                                      input logic irw, input logic rw, input logic rd,
                                      input logic m2r, input logic ill);
        return {st, alu, a, b, pcs, pce, io, mr, mw, irw, rw, rd, m2r, ill};
    endfunction

    // Expected vectors, hand-written from the state table.
    function automatic logic [21:0] e_fetch(input logic rdy);
        return v(4'd0, 4'b0010, 1'b0, 2'b01, 2'b00, rdy, 1'b0, 1'b1, 1'b0, rdy,
                 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [21:0] e_dec(input logic ill);
        return v(4'd1, 4'b0010, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b0, 1'b0, 1'b0, ill);
    endfunction
    function automatic logic [21:0] e_rex(input logic [3:0] alu, input logic ill);
        return v(4'd6, alu, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b0, 1'b0, 1'b0, ill);
    endfunction
    function automatic logic [21:0] e_beq(input logic z);
        return v(4'd8, 4'b0110, 1'b1, 2'b00, 2'b01, z, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    localparam logic [21:0] E_MADR = {4'd2,  4'b0010, 1'b1, 2'b10, 2'b00, 9'b000000000};
    localparam logic [21:0] E_MRD  = {4'd3,  4'b0010, 1'b0, 2'b00, 2'b00, 9'b011000000};
    localparam logic [21:0] E_MWB  = {4'd4,  4'b0010, 1'b0, 2'b00, 2'b00, 9'b000001010};
    localparam logic [21:0] E_MWR  = {4'd5,  4'b0010, 1'b0, 2'b00, 2'b00, 9'b010100000};
    localparam logic [21:0] E_RWB  = {4'd7,  4'b0010, 1'b0, 2'b00, 2'b00, 9'b000001100};
    localparam logic [21:0] E_AEX  = {4'd9,  4'b0010, 1'b1, 2'b10, 2'b00, 9'b000000000};
    localparam logic [21:0] E_AWB  = {4'd10, 4'b0010, 1'b0, 2'b00, 2'b00, 9'b000001000};
    localparam logic [21:0] E_JMP  = {4'd11, 4'b0010, 1'b0, 2'b00, 2'b10, 9'b100000000};

    task automatic ck(input string tag, input logic [21:0] o, input logic [21:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Check the current cycle, then advance to 1 time unit past the next edge.
    task automatic cyc(input string tag, input logic [21:0] e);
        #1;
        ck(tag, obs, e);
        @(posedge clk);
        #1;
    endtask

    logic [5:0] fn_tab [5];
    logic [3:0] al_tab [5];

    initial begin
        fn_tab = '{6'b101010, 6'b100000, 6'b100010, 6'b100100, 6'b100101};
        al_tab = '{4'b0111,   4'b0010,   4'b0110,   4'b0000,   4'b0001};

        reset = 1'b1; mem_ready = 1'b0; opcode = 6'b100011; funct = 6'b0; zero = 1'b0;
        #4;
        ck("reset_state_enables", {12'b0, rst_obs}, 22'd0);
        mem_ready = 1'b1;
        #2;
        ck("reset_ignores_ready", {12'b0, rst_obs}, 22'd0);
        #6 reset = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;

        // lw with mem_ready high: 5 cycles
        mem_ready = 1'b1; opcode = 6'b100011;
        cyc("lw_fetch", e_fetch(1'b1));
        cyc("lw_decode", e_dec(1'b0));
        cyc("lw_memadr", E_MADR);
        cyc("lw_memrd", E_MRD);
        cyc("lw_memwb", E_MWB);

        // R-type, all five functs
        opcode = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            funct = fn_tab[i];
            cyc($sformatf("r%0d_fetch", i), e_fetch(1'b1));
            cyc($sformatf("r%0d_decode", i), e_dec(1'b0));
            cyc($sformatf("r%0d_ex", i), e_rex(al_tab[i], 1'b0));
            cyc($sformatf("r%0d_wb", i), E_RWB);
        end

        // beq taken then not taken; back in FETCH on cycle 4
        opcode = 6'b000100; zero = 1'b1;
        cyc("beq1_fetch", e_fetch(1'b1));
        cyc("beq1_decode", e_dec(1'b0));
        cyc("beq1_ex", e_beq(1'b1));
        zero = 1'b0;
        cyc("beq0_fetch", e_fetch(1'b1));
        cyc("beq0_decode", e_dec(1'b0));
        cyc("beq0_ex", e_beq(1'b0));

        // addi then j
        opcode = 6'b001000;
        cyc("addi_fetch", e_fetch(1'b1));
        cyc("addi_decode", e_dec(1'b0));
        cyc("addi_ex", E_AEX);
        cyc("addi_wb", E_AWB);
        opcode = 6'b000010;
        cyc("j_fetch", e_fetch(1'b1));
        cyc("j_decode", e_dec(1'b0));
        cyc("j_ex", E_JMP);

        // sw: one fetch wait, ready ignored in DECODE/MEMADR, 3 waits in MEMWR
        opcode = 6'b101011; mem_ready = 1'b0;
        cyc("sw_fetch_wait", e_fetch(1'b0));
        mem_ready = 1'b1;
        cyc("sw_fetch", e_fetch(1'b1));
        mem_ready = 1'b0;
        cyc("sw_decode", e_dec(1'b0));
        cyc("sw_memadr", E_MADR);
        cyc("sw_memwr_w0", E_MWR);
        cyc("sw_memwr_w1", E_MWR);
        cyc("sw_memwr_w2", E_MWR);
        mem_ready = 1'b1;
        cyc("sw_memwr_done", E_MWR);
        mem_ready = 1'b0;
        cyc("sw_back_fetch", e_fetch(1'b0));

        // illegal opcode: one-cycle pulse in DECODE
        opcode = 6'b111111; mem_ready = 1'b1;
        cyc("illop_fetch", e_fetch(1'b1));
        cyc("illop_decode", e_dec(1'b1));
        mem_ready = 1'b0;
        cyc("illop_back_fetch", e_fetch(1'b0));

        // illegal funct: pulse in RTYPE_EX, no writeback
        opcode = 6'b000000; funct = 6'b000111; mem_ready = 1'b1;
        cyc("illfn_fetch", e_fetch(1'b1));
        cyc("illfn_decode", e_dec(1'b0));
        cyc("illfn_ex", e_rex(4'b0010, 1'b1));
        mem_ready = 1'b0;
        cyc("illfn_back_fetch", e_fetch(1'b0));

        // reset asserted mid-MEMWR, held 2 cycles
        opcode = 6'b101011; mem_ready = 1'b1;
        cyc("rsw_fetch", e_fetch(1'b1));
        mem_ready = 1'b0;
        cyc("rsw_decode", e_dec(1'b0));
        cyc("rsw_memadr", E_MADR);
        cyc("rsw_memwr", E_MWR);
        #2 reset = 1'b1;
        #1 ck("rst_async_fetch", {12'b0, rst_obs}, 22'd0);
        @(posedge clk); @(posedge clk); #1;
        ck("rst_hold", {12'b0, rst_obs}, 22'd0);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        opcode = 6'b000010; mem_ready = 1'b1;
        cyc("post_rst_fetch", e_fetch(1'b1));
        cyc("post_rst_decode", e_dec(1'b0));
        cyc("post_rst_jump", E_JMP);
        mem_ready = 1'b0;
        cyc("post_rst_back_fetch", e_fetch(1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
